pipeline_hazard_ctrl: RTL and testbench

Central stall/flush controller that drives the busywait and flush inputs of the IF/ID and ID/EX stage registers. It detects load-use hazards between ID and EX and inserts one bubble. It converts taken branches in EX into front-end flushes. It freezes the whole pipeline while instruction or data memory is busy, with a watchdog timeout. It sits beside the stage registers in the core top level and is the producer side of their stall/flush interface.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 10 +
 rtl/pipeline_hazard_ctrl_load_use.sv | 18 +
 rtl/pipeline_hazard_ctrl.sv | 143 ++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// pipeline_hazard_ctrl_pkg: shared FSM state encoding and register constants for the hazard controller.
package pipeline_hazard_ctrl_pkg;
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_BUBBLE   = 2'd1,
    ST_MEM_WAIT = 2'd2,
    ST_TIMEOUT  = 2'd3
  } state_e;
  localparam logic [4:0] REG_X0 = 5'd0;
endpackage

// File: rtl/pipeline_hazard_ctrl_load_use.sv
// hazard_load_use_detect: combinational load-use hazard between the ID instruction and a load in EX.
module hazard_load_use_detect
  import pipeline_hazard_ctrl_pkg::*;
(
  input  logic [4:0] rs1_i,
  input  logic [4:0] rs2_i,
  input  logic       rs1_used_i,
  input  logic       rs2_used_i,
  input  logic [4:0] rd_i,
  input  logic       reg_wb_en_i,
  input  logic       is_load_i,
  output logic       hazard_o
);
  always_comb begin
    hazard_o = is_load_i & reg_wb_en_i & (rd_i != REG_X0) &
               ((rs1_used_i & (rs1_i == rd_i)) | (rs2_used_i & (rs2_i == rd_i)));
  end
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush controller for IF/ID and ID/EX; HAZARD_PERF_CNT_EN adds perf counters.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int PERF_CNT_W  = 32
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [4:0] rs1_label_if_id_i,
  input  logic [4:0] rs2_label_if_id_i,
  input  logic       rs1_used_if_id_i,
  input  logic       rs2_used_if_id_i,
  input  logic [4:0] rd_id_ex_i,
  input  logic       reg_wb_en_id_ex_i,
  input  logic       is_load_instruction_id_ex_i,
  input  logic       branch_taken_ex_i,
  input  logic       imem_busy_i,
  input  logic       dmem_busy_i,
  output logic       busywait_o,
  output logic       stall_pc_o,
  output logic       stall_if_id_o,
  output logic       flush_if_id_o,
  output logic       flush_id_ex_o,
  output logic       mem_timeout_o,
  output logic [1:0] state_o
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [PERF_CNT_W-1:0] bubble_cnt_o,
  output logic [PERF_CNT_W-1:0] flush_cnt_o,
  output logic [PERF_CNT_W-1:0] memstall_cnt_o
`endif
);
  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(MEM_TIMEOUT);
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic pend_q, pend_d, timeout_q, timeout_d;
  logic hazard, busy, bubble_ev, flush_ev;
  hazard_load_use_detect u_detect (
    .rs1_i       (rs1_label_if_id_i),
    .rs2_i       (rs2_label_if_id_i),
    .rs1_used_i  (rs1_used_if_id_i),
    .rs2_used_i  (rs2_used_if_id_i),
    .rd_i        (rd_id_ex_i),
    .reg_wb_en_i (reg_wb_en_id_ex_i),
    .is_load_i   (is_load_instruction_id_ex_i),
    .hazard_o    (hazard)
  );
  always_comb begin
    busy          = imem_busy_i | dmem_busy_i;
    state_d       = state_q;
    cnt_d         = cnt_q;
    pend_d        = pend_q;
    timeout_d     = timeout_q;
    busywait_o    = 1'b0;
    stall_pc_o    = 1'b0;
    stall_if_id_o = 1'b0;
    flush_if_id_o = 1'b0;
    flush_id_ex_o = 1'b0;
    bubble_ev     = 1'b0;
    flush_ev      = 1'b0;
    if (state_q == ST_TIMEOUT) begin
      busywait_o = 1'b1;
    end else if (busy) begin
      busywait_o = 1'b1;
      pend_d     = pend_q | branch_taken_ex_i;
      if (state_q == ST_MEM_WAIT) begin
        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        if (cnt_d == CNT_LIM) begin
          state_d   = ST_TIMEOUT;
          timeout_d = 1'b1;
        end
      end else begin
        cnt_d   = CNT_W'(1);
        state_d = ST_MEM_WAIT;
      end
    end else begin
      // Memory released: RUN rules apply in this same cycle.
      cnt_d   = '0;
      state_d = ST_RUN;
      if (branch_taken_ex_i | pend_q) begin
        flush_if_id_o = 1'b1;
        flush_id_ex_o = 1'b1;
        pend_d        = 1'b0;
        flush_ev      = 1'b1;
      end else if (hazard && state_q != ST_BUBBLE) begin
        stall_pc_o    = 1'b1;
        stall_if_id_o = 1'b1;
        flush_id_ex_o = 1'b1;
        state_d       = ST_BUBBLE;
        bubble_ev     = 1'b1;
      end
    end
    if (rst_i) begin
      busywait_o    = 1'b0;
      stall_pc_o    = 1'b0;
      stall_if_id_o = 1'b0;
      flush_if_id_o = 1'b1;
      flush_id_ex_o = 1'b1;
    end
    mem_timeout_o = timeout_q;
    state_o       = state_q;
  end
`ifdef HAZARD_PERF_CNT_EN
  logic [PERF_CNT_W-1:0] bubble_cnt_q, flush_cnt_q, memstall_cnt_q;
  logic [PERF_CNT_W-1:0] bubble_cnt_d, flush_cnt_d, memstall_cnt_d;
  always_comb begin
    bubble_cnt_d   = bubble_cnt_q + PERF_CNT_W'(bubble_ev);
    flush_cnt_d    = flush_cnt_q + PERF_CNT_W'(flush_ev);
    memstall_cnt_d = memstall_cnt_q + PERF_CNT_W'(busywait_o);
    bubble_cnt_o   = bubble_cnt_q;
    flush_cnt_o    = flush_cnt_q;
    memstall_cnt_o = memstall_cnt_q;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bubble_cnt_q   <= '0;
      flush_cnt_q    <= '0;
      memstall_cnt_q <= '0;
    end else begin
      bubble_cnt_q   <= bubble_cnt_d;
      flush_cnt_q    <= flush_cnt_d;
      memstall_cnt_q <= memstall_cnt_d;
    end
  end
`else
`endif
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_RUN;
      cnt_q     <= '0;
      pend_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      timeout_q <= timeout_d;
    end
  end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed checks of stall, bubble, flush, memory wait and watchdog behaviour.
module tb_pipeline_hazard_ctrl;
  logic clk = 1'b0;
  logic rst;
  logic [4:0] rs1, rs2, rd;
  logic rs1_used, rs2_used, wb_en, is_load, br, imem_busy, dmem_busy;
  logic busywait, stall_pc, stall_if_id, flush_if_id, flush_id_ex, mem_timeout;
  logic [1:0] state;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  pipeline_hazard_ctrl #(.MEM_TIMEOUT(8), .PERF_CNT_W(16)) dut (
    .clk_i                       (clk),
    .rst_i                       (rst),
    .rs1_label_if_id_i           (rs1),
    .rs2_label_if_id_i           (rs2),
    .rs1_used_if_id_i            (rs1_used),
    .rs2_used_if_id_i            (rs2_used),
    .rd_id_ex_i                  (rd),
    .reg_wb_en_id_ex_i           (wb_en),
    .is_load_instruction_id_ex_i (is_load),
    .branch_taken_ex_i           (br),
    .imem_busy_i                 (imem_busy),
    .dmem_busy_i                 (dmem_busy),
    .busywait_o                  (busywait),
    .stall_pc_o                  (stall_pc),
    .stall_if_id_o               (stall_if_id),
    .flush_if_id_o               (flush_if_id),
    .flush_id_ex_o               (flush_id_ex),
    .mem_timeout_o               (mem_timeout),
    .state_o                     (state)
  );
  // {busywait, stall_pc, stall_if_id, flush_if_id, flush_id_ex, mem_timeout, state}
  function automatic logic [7:0] outs();
    return {busywait, stall_pc, stall_if_id, flush_if_id, flush_id_ex, mem_timeout, state};
  endfunction
  task automatic idle();
    rs1 = 5'd0; rs2 = 5'd0; rd = 5'd0;
    rs1_used = 1'b0; rs2_used = 1'b0; wb_en = 1'b0; is_load = 1'b0;
    br = 1'b0; imem_busy = 1'b0; dmem_busy = 1'b0;
  endtask
  task automatic set_hazard();
    is_load = 1'b1; wb_en = 1'b1; rd = 5'd5; rs1 = 5'd5; rs1_used = 1'b1;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    idle();
    step();
    @(negedge clk);
    checks++;
    if (outs() !== 8'h18) begin errors++; $display("FAIL reset_outputs got=%b exp=%b", outs(), 8'h18); end
    step();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (outs() !== 8'h00) begin errors++; $display("FAIL reset_release got=%b exp=%b", outs(), 8'h00); end
    step();
  endtask
  task automatic test_load_use();
    set_hazard();
    @(negedge clk);
    checks++;
    if (outs() !== 8'h68) begin errors++; $display("FAIL load_use_stall got=%b exp=%b", outs(), 8'h68); end
    step();
    @(negedge clk);
    checks++;
    if (outs() !== 8'h01) begin errors++; $display("FAIL load_use_bubble got=%b exp=%b", outs(), 8'h01); end
    step();
    idle();
    @(negedge clk);
    checks++;
    if (outs() !== 8'h00) begin errors++; $display("FAIL load_use_after got=%b exp=%b", outs(), 8'h00); end
    step();
  endtask
  task automatic test_no_false_hazard();
    set_hazard(); rd = 5'd0; rs1 = 5'd0;
    @(negedge clk);
    checks++;
    if (outs() !== 8'h00) begin errors++; $display("FAIL no_hazard_x0 got=%b exp=%b", outs(), 8'h00); end
    step();
    set_hazard(); rs1_used = 1'b0; rs2 = 5'd5; rs2_used = 1'b0;
    @(negedge clk);
    checks++;
    if (outs() !== 8'h00) begin errors++; $display("FAIL no_hazard_unused got=%b exp=%b", outs(), 8'h00); end
    step();
    set_hazard(); is_load = 1'b0;
    @(negedge clk);
    checks++;
    if (outs() !== 8'h00) begin errors++; $display("FAIL no_hazard_noload got=%b exp=%b", outs(), 8'h00); end
    step();
    idle(); set_hazard(); rs1_used = 1'b0; rs2 = 5'd5; rs2_used = 1'b1;
    @(negedge clk);
    checks++;
    if (outs() !== 8'h68) begin errors++; $display("FAIL hazard_rs2 got=%b exp=%b", outs(), 8'h68); end
    step();
    idle();
    step();
  endtask
  task automatic test_branch_hazard();
    set_hazard(); br = 1'b1;
    @(negedge clk);
    checks++;
    if (outs() !== 8'h18) begin errors++; $display("FAIL branch_hazard_flush got=%b exp=%b", outs(), 8'h18); end
    step();
    idle();
    @(negedge clk);
    checks++;
    if (outs() !== 8'h00) begin errors++; $display("FAIL branch_no_bubble got=%b exp=%b", outs(), 8'h00); end
    step();
  endtask
  task automatic test_branch_busy();
    logic [7:0] exp_v;
    for (int i = 1; i <= 4; i++) begin
      dmem_busy = 1'b1;
      br = (i == 2);
      exp_v = (i == 1) ? 8'h80 : 8'h82;
      @(negedge clk);
      checks++;
      if (outs() !== exp_v) begin errors++; $display("FAIL branch_busy_c%0d got=%b exp=%b", i, outs(), exp_v); end
      step();
    end
    idle();
    @(negedge clk);
    checks++;
    if (outs() !== 8'h1a) begin errors++; $display("FAIL pending_flush got=%b exp=%b", outs(), 8'h1a); end
    step();
    @(negedge clk);
    checks++;
    if (outs() !== 8'h00) begin errors++; $display("FAIL pending_once got=%b exp=%b", outs(), 8'h00); end
    step();
  endtask
  task automatic test_busy_drop_hazard();
    imem_busy = 1'b1;
    @(negedge clk);
    checks++;
    if (outs() !== 8'h80) begin errors++; $display("FAIL drop_busy got=%b exp=%b", outs(), 8'h80); end
    step();
    imem_busy = 1'b0;
    set_hazard();
    @(negedge clk);
    checks++;
    if (outs() !== 8'h6a) begin errors++; $display("FAIL drop_hazard got=%b exp=%b", outs(), 8'h6a); end
    step();
    @(negedge clk);
    checks++;
    if (outs() !== 8'h01) begin errors++; $display("FAIL drop_bubble got=%b exp=%b", outs(), 8'h01); end
    step();
    idle();
    step();
  endtask
  task automatic test_timeout();
    logic [7:0] exp_v;
    imem_busy = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      exp_v = (i == 1) ? 8'h80 : 8'h82;
      @(negedge clk);
      checks++;
      if (outs() !== exp_v) begin errors++; $display("FAIL timeout_wait_c%0d got=%b exp=%b", i, outs(), exp_v); end
      step();
    end
    @(negedge clk);
    checks++;
    if (outs() !== 8'h87) begin errors++; $display("FAIL timeout_enter got=%b exp=%b", outs(), 8'h87); end
    step();
    imem_busy = 1'b0;
    step();
    @(negedge clk);
    checks++;
    if (outs() !== 8'h87) begin errors++; $display("FAIL timeout_sticky got=%b exp=%b", outs(), 8'h87); end
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (outs() !== 8'h00) begin errors++; $display("FAIL timeout_cleared got=%b exp=%b", outs(), 8'h00); end
    step();
  endtask
  task automatic test_reset_bubble();
    set_hazard();
    step();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (outs() !== 8'h19) begin errors++; $display("FAIL reset_in_bubble got=%b exp=%b", outs(), 8'h19); end
    step();
    rst = 1'b0;
    idle();
    @(negedge clk);
    checks++;
    if (outs() !== 8'h00) begin errors++; $display("FAIL reset_bubble_after got=%b exp=%b", outs(), 8'h00); end
    step();
  endtask
  initial begin
    test_reset();
    test_load_use();
    test_no_false_hazard();
    test_branch_hazard();
    test_branch_busy();
    test_busy_drop_hazard();
    test_timeout();
    test_reset_bubble();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
